// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot program loader.
package prog_loader_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDRESS_WIDTH = 4;

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// Wrap-around running sum of frame payload bytes.
module loader_csum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames payload into RAM, then releases the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_data,
  output logic                     cpu_run,
  output logic                     load_err
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [WIDTH:0] DEPTH_W = (WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] MAGIC_W = WIDTH'(MAGIC);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] last;
  logic [WIDTH-1:0]         sum;
  logic                     accept;
  logic                     len_ok;
  logic                     is_magic;
  logic                     sum_clr;
  logic                     sum_add;

  assign accept   = in_valid && in_ready;
  assign is_magic = in_data == MAGIC_W;
  assign len_ok   = (in_data != '0) &&
                    ({1'b0, in_data} <= DEPTH_W);
  assign sum_clr  = accept && (state == ST_LEN);
  assign sum_add  = accept && (state == ST_DATA);

  loader_csum #(
    .WIDTH(WIDTH)
  ) u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sum_clr),
    .add_en(sum_add),
    .din   (in_data),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last     <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      cpu_run  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      in_ready <= (state != ST_DONE);
      if (accept) begin
        unique case (state)
          ST_IDLE, ST_ERR: begin
            if (is_magic) state <= ST_LEN;
          end
          ST_LEN: begin
            if (len_ok) begin
              state    <= ST_DATA;
              cnt      <= '0;
              last     <= ADDRESS_WIDTH'(in_data - 1'b1);
              load_err <= 1'b0;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
          ST_DATA: begin
            mem_we   <= 1'b1;
            mem_addr <= cnt;
            mem_data <= in_data;
            // stop at the last index so the counter never wraps
            if (cnt == last) state <= ST_CSUM;
            else cnt <= cnt + 1'b1;
          end
          ST_CSUM: begin
            if (in_data == sum) begin
              state    <= ST_DONE;
              cpu_run  <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames, queued RAM writes.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_run;
  logic       load_err;

  prog_loader #(
    .WIDTH(8),
    .ADDRESS_WIDTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .cpu_run (cpu_run),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  gap = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  wr_t e;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, mem_addr}, {28'd0, e.a});
        chk("wr_data", {24'd0, mem_data}, {24'd0, e.d});
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit wr,
                      input logic [3:0] a);
    int n;
    n = 0;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    if (wr) exp_q.push_back('{a: a, d: b, c: cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_rdy"}, {31'd0, in_ready}, 0);
    chk({t, "_we"}, {31'd0, mem_we}, 0);
    chk({t, "_addr"}, {28'd0, mem_addr}, 0);
    chk({t, "_data"}, {24'd0, mem_data}, 0);
    chk({t, "_run"}, {31'd0, cpu_run}, 0);
    chk({t, "_err"}, {31'd0, load_err}, 0);
  endtask

  task automatic chk_status(input string t, input logic run,
                            input logic err, input logic rdy);
    chk({t, "_run"}, {31'd0, cpu_run}, {31'd0, run});
    chk({t, "_err"}, {31'd0, load_err}, {31'd0, err});
    chk({t, "_rdy"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({t, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic full_frame();
    send(8'hA5, 0, 0);
    send(8'h10, 0, 0);
    for (int i = 0; i < 16; i++) send(8'(i), 1, 4'(i));
    send(8'h78, 0, 0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_at_release", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("rdy_after_release", {31'd0, in_ready}, 1);

    // basic good frame, then ignored traffic while done
    send(8'hA5, 0, 0);
    send(8'h03, 0, 0);
    send(8'h1C, 1, 0);
    send(8'h2E, 1, 1);
    send(8'hF0, 1, 2);
    send(8'h3A, 0, 0);
    idle();
    chk_status("A", 1, 0, 0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    idle();
    chk_status("A_hold", 1, 0, 0);

    do_reset();
    send(8'hA5, 0, 0);
    send(8'h02, 0, 0);
    send(8'h10, 1, 0);
    send(8'h20, 1, 1);
    send(8'h31, 0, 0);
    idle();
    chk_status("B_bad", 0, 1, 1);
    send(8'hA5, 0, 0);
    send(8'h01, 0, 0);
    send(8'h05, 1, 0);
    send(8'h05, 0, 0);
    idle();
    chk_status("B_good", 1, 0, 0);

    do_reset();
    send(8'h00, 0, 0);
    send(8'hFF, 0, 0);
    idle();
    chk_status("C_idle", 0, 0, 1);
    send(8'hA5, 0, 0);
    send(8'h00, 0, 0);
    idle();
    chk_status("C_len0", 0, 1, 1);
    send(8'hA5, 0, 0);
    send(8'h11, 0, 0);
    idle();
    chk_status("C_len17", 0, 1, 1);

    do_reset();
    full_frame();
    chk_status("D", 1, 0, 0);

    do_reset();
    gap = 1'b1;
    full_frame();
    gap = 1'b0;
    chk_status("D_gaps", 1, 0, 0);

    // reset lands while a data write is still pending
    do_reset();
    send(8'hA5, 0, 0);
    send(8'h03, 0, 0);
    send(8'h11, 1, 0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("E_async");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hA5, 0, 0);
    send(8'h01, 0, 0);
    send(8'h07, 1, 0);
    send(8'h07, 0, 0);
    idle();
    chk_status("E_restart", 1, 0, 0);

    do_reset();
    send(8'hA5, 0, 0);
    send(8'h02, 0, 0);
    send(8'hA5, 1, 0);
    send(8'h01, 1, 1);
    send(8'hA6, 0, 0);
    idle();
    chk_status("F_magic_data", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
